// File: rtl/instruction_fetch.sv
// Instruction fetch stage: credit-limited, in-order fetch into a small {pc, instruction}
// buffer, with redirect flush and dropping of responses that belong to abandoned requests.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc_next
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Request channel: a request transfers on a rising edge where imem_req_valid && imem_req_ready.
    // Responses come back in request order and cannot be backpressured.

    // Fetch address and request accounting.
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] live_q, live_d;
    logic [CW-1:0] drop_q, drop_d;

    // In-order tags of issued addresses, consumed by live responses.
    logic [31:0]   pcq_q [FIFO_DEPTH];
    logic [AW-1:0] pcq_wr_q, pcq_wr_d;
    logic [AW-1:0] pcq_rd_q, pcq_rd_d;

    // Instruction buffer.
    logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]   fifo_data_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   last_pc_q, last_pc_d;

    logic [CW-1:0] inflight;
    logic [CW-1:0] occupancy;
    logic          credit_ok;
    logic          req_fire;
    logic          rsp_drop;
    logic          rsp_live;
    logic          rsp_consumed;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_push;
    logic          fifo_pop;
    logic [31:0]   head_pc;
    logic [31:0]   head_data;

    // Handshake and credit decode.
    always_comb begin
        inflight       = live_q + drop_q;
        occupancy      = inflight + count_q;
        credit_ok      = occupancy < DEPTH_C;
        imem_req_valid = !rst && !redirect_valid && credit_ok;
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;

        rsp_drop       = imem_rsp_valid && (drop_q != '0);
        rsp_live       = imem_rsp_valid && (drop_q == '0) && (live_q != '0);
        rsp_consumed   = rsp_drop || rsp_live;

        fifo_empty     = (count_q == '0);
        fifo_full      = (count_q == DEPTH_C);
        head_pc        = fifo_pc_q[rd_ptr_q];
        head_data      = fifo_data_q[rd_ptr_q];

        id_valid       = !fifo_empty && !redirect_valid;
        fifo_pop       = id_valid && !stall;
        // A response landing in a redirect cycle belongs to the old path.
        fifo_push      = !rst && rsp_live && !redirect_valid;
    end

    // Decode-facing bundle; PCs hold their last presented value while idle.
    always_comb begin
        id_pc          = id_valid ? head_pc : last_pc_q;
        id_instruction = id_valid ? head_data : NOP;
        id_pc_next     = id_pc + 32'd4;
        last_pc_d      = id_valid ? head_pc : last_pc_q;
    end

    // Next-state for fetch PC, counters and pointers.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        live_d     = live_q;
        drop_d     = drop_q;
        pcq_wr_d   = pcq_wr_q;
        pcq_rd_d   = pcq_rd_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            // Every outstanding request now returns a word that must be discarded.
            drop_d     = drop_q + live_q - CW'(rsp_consumed);
            live_d     = '0;
            pcq_wr_d   = '0;
            pcq_rd_d   = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                pcq_wr_d   = pcq_wr_q + AW'(1);
            end
            if (rsp_drop) begin
                drop_d = drop_q - CW'(1);
            end
            if (rsp_live) begin
                pcq_rd_d = pcq_rd_q + AW'(1);
            end
            live_d = live_q + CW'(req_fire) - CW'(rsp_live);

            if (fifo_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (fifo_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(fifo_push) - CW'(fifo_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            live_q     <= '0;
            drop_q     <= '0;
            pcq_wr_q   <= '0;
            pcq_rd_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_pc_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            live_q     <= live_d;
            drop_q     <= drop_d;
            pcq_wr_q   <= pcq_wr_d;
            pcq_rd_q   <= pcq_rd_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            last_pc_q  <= last_pc_d;
        end
    end

    // Storage arrays carry no reset; occupancy is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_pc_q[wr_ptr_q]   <= pcq_q[pcq_rd_q];
            fifo_data_q[wr_ptr_q] <= imem_rsp_data;
        end
        if (req_fire) begin
            pcq_q[pcq_wr_q] <= fetch_pc_q;
        end
    end

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && fifo_full && !fifo_pop));
    a_tag_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(req_fire && (live_q == DEPTH_C)));

endmodule
